breath_ramp_gen: RTL and testbench

- Upstream timebase and brightness-ramp source for the LED breathing/PWM stage.
- Generates a divided tick and a step strobe, and runs a ramp state machine.
- The ramp state machine produces a rising, holding, falling and holding duty value that the downstream PWM compare consumes.
- Supports one-shot and continuous breathing, pause (en low) and synchronous abort.

---
 rtl/breath_ramp_if.sv | 17 +
 rtl/breath_ramp_gen.sv | 102 ++++++++++
 tb/tb_breath_ramp_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/breath_ramp_if.sv
// breath_ramp_if: control and status bundle between the breathing ramp source and its user
interface breath_ramp_if #(
    parameter int DUTY_W = 10
);
    logic              en;
    logic              mode;
    logic              abort;
    logic              tick;
    logic              step;
    logic [DUTY_W-1:0] duty;
    logic              duty_upd;
    logic              dir;
    logic              busy;
    logic              done;
    modport master (output en, mode, abort, input tick, step, duty, duty_upd, dir, busy, done);
    modport slave  (input en, mode, abort, output tick, step, duty, duty_upd, dir, busy, done);
endinterface

// File: rtl/breath_ramp_gen.sv
// breath_ramp_gen: prescaled tick/step timebase driving a rise/hold/fall/hold duty ramp for the LED PWM
module breath_ramp_gen #(
    parameter int TICK_DIV   = 50,
    parameter int STEP_TICKS = 1000,
    parameter int DUTY_W     = 10,
    parameter int DUTY_MAX   = 999,
    parameter int STEP_SIZE  = 1,
    parameter int HOLD_STEPS = 0
) (
    input logic          clk,
    input logic          rst,
    breath_ramp_if.slave br
);
    typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;
    localparam logic [DUTY_W:0] MAX_V  = (DUTY_W + 1)'(DUTY_MAX);
    localparam logic [DUTY_W:0] STEP_V = (DUTY_W + 1)'(STEP_SIZE);
    state_t            state, state_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic [15:0]       pre_cnt, st_cnt, hold_cnt, hold_n;
    logic              tick_q, step_q, upd_q, done_q, done_n;
    logic              pre_wrap, st_wrap, last_hold, adv;
    logic [DUTY_W:0]   sum, up_v, dn_v;
    assign pre_wrap  = pre_cnt == 16'(TICK_DIV - 1);
    assign st_wrap   = st_cnt == 16'(STEP_TICKS - 1);
    assign last_hold = hold_cnt == 16'(HOLD_STEPS - 1);
    assign adv       = step_q & br.en;
    assign sum       = {1'b0, duty} + STEP_V;
    assign up_v      = sum > MAX_V ? MAX_V : sum;
    assign dn_v      = {1'b0, duty} >= STEP_V ? {1'b0, duty} - STEP_V : '0;
    always_comb begin
        state_n = state;
        duty_n  = duty;
        hold_n  = hold_cnt;
        done_n  = 1'b0;
        if (br.abort) begin
            state_n = IDLE;
            duty_n  = '0;
            hold_n  = '0;
        end else if (state == IDLE) begin
            state_n = br.en ? RISE : IDLE;
        end else if (adv) begin
            unique case (state)
                RISE: begin
                    duty_n  = up_v[DUTY_W-1:0];
                    state_n = up_v != MAX_V ? RISE : HOLD_STEPS == 0 ? FALL : HOLD_HI;
                end
                HOLD_HI: begin
                    hold_n  = last_hold ? '0 : hold_cnt + 16'd1;
                    state_n = last_hold ? FALL : HOLD_HI;
                end
                FALL: begin
                    duty_n  = dn_v[DUTY_W-1:0];
                    state_n = dn_v != '0 ? FALL : HOLD_STEPS != 0 ? HOLD_LO : br.mode ? RISE : IDLE;
                    done_n  = dn_v == '0 && HOLD_STEPS == 0 && !br.mode;
                end
                HOLD_LO: begin
                    hold_n  = last_hold ? '0 : hold_cnt + 16'd1;
                    state_n = !last_hold ? HOLD_LO : br.mode ? RISE : IDLE;
                    done_n  = last_hold && !br.mode;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // tick/step strobes are held while paused so the pending count is consumed on resume
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            pre_cnt  <= '0;
            st_cnt   <= '0;
            hold_cnt <= '0;
            tick_q   <= 1'b0;
            step_q   <= 1'b0;
            upd_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            hold_cnt <= hold_n;
            upd_q    <= duty_n != duty;
            done_q   <= done_n;
            if (br.en) begin
                pre_cnt <= pre_wrap ? '0 : pre_cnt + 16'd1;
                tick_q  <= pre_wrap;
                step_q  <= tick_q & st_wrap;
                if (tick_q) st_cnt <= st_wrap ? '0 : st_cnt + 16'd1;
            end
            if (br.abort) begin
                st_cnt <= '0;
                step_q <= 1'b0;
            end
        end
    end
    assign br.tick     = tick_q & br.en;
    assign br.step     = step_q & br.en;
    assign br.duty_upd = upd_q & br.en;
    assign br.done     = done_q & br.en;
    assign br.duty     = duty;
    assign br.dir      = state == RISE || state == HOLD_HI;
    assign br.busy     = state != IDLE;
endmodule

// File: tb/tb_breath_ramp_gen.sv
// tb_breath_ramp_gen: directed checks of timebase, one-shot and continuous breathing, pause, abort and reset
module tb_breath_ramp_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int checks = 0, errors = 0, cyc_n = 0;
    int n_upd, n_done, n_tog, max_duty;
    logic [3:0] upd_seq [8];
    logic [3:0] exp_seq [8] = '{4'd3, 4'd6, 4'd9, 4'd10, 4'd7, 4'd4, 4'd1, 4'd0};
    logic prev_dir;

    breath_ramp_if #(.DUTY_W(4)) a_if ();
    breath_ramp_if #(.DUTY_W(4)) b_if ();

    breath_ramp_gen #(.TICK_DIV(4), .STEP_TICKS(2), .DUTY_W(4), .DUTY_MAX(10), .STEP_SIZE(3), .HOLD_STEPS(1))
        dut_a (.clk(clk), .rst(rst_a), .br(a_if));
    breath_ramp_gen #(.TICK_DIV(4), .STEP_TICKS(2), .DUTY_W(4), .DUTY_MAX(10), .STEP_SIZE(3), .HOLD_STEPS(0))
        dut_b (.clk(clk), .rst(rst_b), .br(b_if));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.en = 1'b0; a_if.mode = 1'b0; a_if.abort = 1'b0;
        b_if.en = 1'b0; b_if.mode = 1'b0; b_if.abort = 1'b0;
        step_clk(1);
        chk("reset_outs_first", 32'({a_if.tick, a_if.step, a_if.duty, a_if.duty_upd, a_if.dir, a_if.busy, a_if.done}), 0);
        step_clk(2);
        chk("reset_outs_a", 32'({a_if.tick, a_if.step, a_if.duty, a_if.duty_upd, a_if.dir, a_if.busy, a_if.done}), 0);
        chk("reset_outs_b", 32'({b_if.tick, b_if.step, b_if.duty, b_if.duty_upd, b_if.dir, b_if.busy, b_if.done}), 0);
        rst_a = 1'b0;
        a_if.en = 1'b1;
        cyc_n = 0;
        n_upd = 0;
        n_done = 0;
        for (int c = 1; c <= 82; c++) begin
            step_clk(1);
            chk("tick", 32'(a_if.tick), 32'(c % 4 == 0));
            chk("step", 32'(a_if.step), 32'(c >= 9 && c % 8 == 1));
            if (a_if.duty_upd) begin
                if (n_upd < 8) upd_seq[n_upd] = a_if.duty;
                n_upd++;
            end
            n_done += int'(a_if.done);
            if (c == 1) chk("busy_start", 32'(a_if.busy), 1);
            if (c == 34) chk("dir_hold_hi", 32'(a_if.dir), 1);
            if (c == 42) chk("dir_fall", 32'(a_if.dir), 0);
            if (c == 82) begin
                chk("done_pulse", 32'(a_if.done), 1);
                chk("busy_drop", 32'(a_if.busy), 0);
                chk("duty_idle", 32'(a_if.duty), 0);
            end
        end
        chk("upd_count", n_upd, 8);
        for (int i = 0; i < 8; i++) chk("upd_seq", 32'(upd_seq[i]), 32'(exp_seq[i]));
        chk("done_count", n_done, 1);
        step_clk(1);
        chk("rearm_busy", 32'(a_if.busy), 1);
        chk("rearm_done_low", 32'(a_if.done), 0);
        a_if.mode = 1'b1;
        prev_dir = a_if.dir;
        n_tog = 0;
        n_done = 0;
        max_duty = 0;
        while (cyc_n < 341) begin
            step_clk(1);
            if (a_if.dir !== prev_dir) begin
                n_tog++;
                chk("dir_toggle_duty", 32'(a_if.duty), prev_dir ? 10 : 0);
                prev_dir = a_if.dir;
            end
            if (int'(a_if.duty) > max_duty) max_duty = int'(a_if.duty);
            n_done += int'(a_if.done);
        end
        chk("cont_toggles", n_tog, 6);
        chk("cont_no_done", n_done, 0);
        chk("cont_max_duty", max_duty, 10);
        chk("pre_pause_duty", 32'(a_if.duty), 6);
        chk("pre_pause_dir", 32'(a_if.dir), 1);
        a_if.en = 1'b0;
        repeat (37) begin
            step_clk(1);
            chk("pause_quiet", 32'({a_if.tick, a_if.step, a_if.duty_upd}), 0);
            chk("pause_duty", 32'(a_if.duty), 6);
        end
        a_if.en = 1'b1;
        repeat (5) begin
            step_clk(1);
            chk("resume_tick", 32'(a_if.tick), 32'(cyc_n == 381));
            chk("resume_step", 32'(a_if.step), 32'(cyc_n == 382));
            chk("resume_duty", 32'(a_if.duty), cyc_n == 383 ? 9 : 6);
            chk("resume_upd", 32'(a_if.duty_upd), 32'(cyc_n == 383));
        end
        step_clk(7);
        chk("abort_pre_step", 32'(a_if.step), 1);
        chk("abort_pre_duty", 32'(a_if.duty), 9);
        a_if.abort = 1'b1;
        step_clk(1);
        chk("abort_busy", 32'(a_if.busy), 0);
        chk("abort_duty", 32'(a_if.duty), 0);
        chk("abort_upd", 32'(a_if.duty_upd), 1);
        chk("abort_done", 32'(a_if.done), 0);
        step_clk(1);
        chk("abort_idle_upd", 32'(a_if.duty_upd), 0);
        chk("abort_idle_busy", 32'(a_if.busy), 0);
        a_if.abort = 1'b0;
        step_clk(1);
        chk("abort_rearm", 32'(a_if.busy), 1);
        rst_b = 1'b0;
        b_if.en = 1'b1;
        cyc_n = 0;
        for (int c = 1; c <= 42; c++) begin
            step_clk(1);
            if (c == 26) chk("b_duty_9", 32'(b_if.duty), 9);
            if (c == 34) begin
                chk("b_duty_10", 32'(b_if.duty), 10);
                chk("b_no_hold_dir", 32'(b_if.dir), 0);
            end
            if (c == 42) begin
                chk("b_duty_7", 32'(b_if.duty), 7);
                chk("b_busy_fall", 32'(b_if.busy), 1);
            end
        end
        rst_b = 1'b1;
        step_clk(1);
        chk("b_reset_mid_fall", 32'({b_if.tick, b_if.step, b_if.duty, b_if.duty_upd, b_if.dir, b_if.busy, b_if.done}), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
